// File: rtl/spell_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spell_mem_arbiter
// Purpose  : Two-port arbiter/sequencer sharing the spell internal memory
//            port between the program loader (port 0) and the CPU core
//            (port 1). Latches the winning request, runs the memory
//            select/data_ready handshake, returns read data with a one-cycle
//            ack and forces a select-low gap between transactions.
// Config   : SPELL_ARB_ROUND_ROBIN_EN - when defined, ties are broken
//            round-robin against the last grant; otherwise port 0 always
//            wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
module spell_mem_arbiter (
  input  logic       clk,
  input  logic       rst,
  // port 0 : program loader
  input  logic       p0_req,
  input  logic [7:0] p0_addr,
  input  logic [7:0] p0_wdata,
  input  logic       p0_data_sel,
  input  logic       p0_write,
  output logic       p0_ack,
  output logic [7:0] p0_rdata,
  // port 1 : CPU core
  input  logic       p1_req,
  input  logic [7:0] p1_addr,
  input  logic [7:0] p1_wdata,
  input  logic       p1_data_sel,
  input  logic       p1_write,
  output logic       p1_ack,
  output logic [7:0] p1_rdata,
  // memory side
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_data_sel,
  output logic       mem_write,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  // status
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  // Port of the transaction in flight; in the round-robin build it doubles
  // as the grant history used to break ties.
  logic       grant_q, grant_d;
  logic       mem_select_q, mem_select_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       mem_data_sel_q, mem_data_sel_d;
  logic       mem_write_q, mem_write_d;
  logic       p0_ack_q, p0_ack_d;
  logic       p1_ack_q, p1_ack_d;
  logic [7:0] p0_rdata_q, p0_rdata_d;
  logic [7:0] p1_rdata_q, p1_rdata_d;
  logic       busy_q, busy_d;

  logic       w_any_req;
  logic       w_pick;

  assign w_any_req = p0_req | p1_req;

  // Choose which requester wins when leaving IDLE.
  always_comb begin
    w_pick = 1'b0;
    if (p0_req && p1_req) begin
`ifdef SPELL_ARB_ROUND_ROBIN_EN
      w_pick = ~grant_q;
`else
      w_pick = 1'b0;
`endif
    end else if (p1_req) begin
      w_pick = 1'b1;
    end else begin
      w_pick = 1'b0;
    end
  end

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    mem_select_d   = mem_select_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_data_sel_d = mem_data_sel_q;
    mem_write_d    = mem_write_q;
    p0_ack_d       = 1'b0;
    p1_ack_d       = 1'b0;
    p0_rdata_d     = p0_rdata_q;
    p1_rdata_d     = p1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (w_any_req) begin
          state_d      = ST_BUSY;
          grant_d      = w_pick;
          mem_select_d = 1'b1;
          if (w_pick) begin
            mem_addr_d     = p1_addr;
            mem_wdata_d    = p1_wdata;
            mem_data_sel_d = p1_data_sel;
            mem_write_d    = p1_write;
          end else begin
            mem_addr_d     = p0_addr;
            mem_wdata_d    = p0_wdata;
            mem_data_sel_d = p0_data_sel;
            mem_write_d    = p0_write;
          end
        end
      end

      ST_BUSY: begin
        // mem_* held stable; no timeout, wait for the memory indefinitely.
        if (mem_ready) begin
          state_d      = ST_RELEASE;
          mem_select_d = 1'b0;
          if (grant_q) begin
            p1_ack_d = 1'b1;
            if (!mem_write_q) begin
              p1_rdata_d = mem_rdata;
            end
          end else begin
            p0_ack_d = 1'b1;
            if (!mem_write_q) begin
              p0_rdata_d = mem_rdata;
            end
          end
        end
      end

      ST_RELEASE: begin
        // One cycle of select low lets the memory drop data_ready.
        state_d = ST_IDLE;
      end

      default: begin
        state_d      = ST_IDLE;
        mem_select_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grant_q        <= 1'b1;
      mem_select_q   <= 1'b0;
      mem_addr_q     <= 8'h00;
      mem_wdata_q    <= 8'h00;
      mem_data_sel_q <= 1'b0;
      mem_write_q    <= 1'b0;
      p0_ack_q       <= 1'b0;
      p1_ack_q       <= 1'b0;
      p0_rdata_q     <= 8'h00;
      p1_rdata_q     <= 8'h00;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      mem_select_q   <= mem_select_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_data_sel_q <= mem_data_sel_d;
      mem_write_q    <= mem_write_d;
      p0_ack_q       <= p0_ack_d;
      p1_ack_q       <= p1_ack_d;
      p0_rdata_q     <= p0_rdata_d;
      p1_rdata_q     <= p1_rdata_d;
      busy_q         <= busy_d;
    end
  end

  assign mem_select   = mem_select_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_data_sel = mem_data_sel_q;
  assign mem_write    = mem_write_q;
  assign p0_ack       = p0_ack_q;
  assign p1_ack       = p1_ack_q;
  assign p0_rdata     = p0_rdata_q;
  assign p1_rdata     = p1_rdata_q;
  assign busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spell_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spell_mem_arbiter
// Purpose  : Self-checking bench for spell_mem_arbiter with a behavioural
//            memory (configurable wait states) and a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spell_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       p0_req = 1'b0, p1_req = 1'b0;
  logic [7:0] p0_addr = 8'h00, p1_addr = 8'h00;
  logic [7:0] p0_wdata = 8'h00, p1_wdata = 8'h00;
  logic       p0_data_sel = 1'b0, p1_data_sel = 1'b0;
  logic       p0_write = 1'b0, p1_write = 1'b0;
  logic       p0_ack, p1_ack;
  logic [7:0] p0_rdata, p1_rdata;
  logic       mem_select, mem_data_sel, mem_write;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ready = 1'b0;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  spell_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_data_sel(p0_data_sel), .p0_write(p0_write),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_data_sel(p1_data_sel), .p1_write(p1_write),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_sel(mem_data_sel), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural memory ----------------
  // Unwritten locations return a fixed address pattern.
  bit [7:0] mem_code [256];
  bit [7:0] mem_data [256];
  bit       mem_code_vld [256];
  bit       mem_data_vld [256];
  int       mem_wait = 0;
  int       mem_cnt  = 0;

  function automatic logic [7:0] dflt(input logic [7:0] a, input logic ds);
    return 8'(a * 8'd37 + (ds ? 8'd91 : 8'd13));
  endfunction

  always @(posedge clk) begin
    if (rst || !mem_select) begin
      mem_ready <= 1'b0;
      mem_cnt   <= 0;
    end else if (!mem_ready) begin
      if (mem_cnt >= mem_wait) begin
        mem_ready <= 1'b1;
        if (mem_write) begin
          if (mem_data_sel) begin
            mem_data[mem_addr] <= mem_wdata; mem_data_vld[mem_addr] <= 1'b1;
          end else begin
            mem_code[mem_addr] <= mem_wdata; mem_code_vld[mem_addr] <= 1'b1;
          end
        end
        if (mem_data_sel)
          mem_rdata <= mem_data_vld[mem_addr] ? mem_data[mem_addr] : dflt(mem_addr, 1'b1);
        else
          mem_rdata <= mem_code_vld[mem_addr] ? mem_code[mem_addr] : dflt(mem_addr, 1'b0);
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  logic [7:0] ref_code [256];
  logic [7:0] ref_data [256];
  logic [7:0] m_rdata [2];
  logic       m_last;

  task automatic model_txn(input int port, input logic [7:0] addr, wdata,
                           input logic dsel, wr, output logic [7:0] exp_rd);
    if (wr) begin
      if (dsel) ref_data[addr] = wdata; else ref_code[addr] = wdata;
    end else begin
      m_rdata[port] = dsel ? ref_data[addr] : ref_code[addr];
    end
    m_last = (port != 0);
    exp_rd = m_rdata[port];
  endtask

  // ---------------- stimulus helpers ----------------
  int         t_lat, t_sel_hi;
  bit         t_other_ack, t_stable, t_timeout, t_sel_at_ack, t_busy_at_ack, t_busy_after;
  logic [7:0] t_rdata, t_seen_addr, t_seen_wdata;
  logic       t_seen_write, t_seen_dsel;

  task automatic drive_port(input int port, input logic [7:0] addr, wdata,
                            input logic dsel, wr, req);
    if (port == 0) begin
      p0_addr = addr; p0_wdata = wdata; p0_data_sel = dsel; p0_write = wr; p0_req = req;
    end else begin
      p1_addr = addr; p1_wdata = wdata; p1_data_sel = dsel; p1_write = wr; p1_req = req;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1; m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
  endtask

  // Issue one single-port request and record what happens until its ack.
  // Returns positioned at the negedge of the cycle after the ack.
  task automatic run_txn(input int port, input logic [7:0] addr, wdata,
                         input logic dsel, wr);
    int  cyc;
    bit  done, seen;
    logic [17:0] first, cur;
    @(negedge clk);
    drive_port(port, addr, wdata, dsel, wr, 1'b1);
    cyc = 0; done = 0; seen = 0; first = '0;
    t_lat = 0; t_sel_hi = 0; t_other_ack = 0; t_stable = 1; t_timeout = 0;
    t_sel_at_ack = 1; t_busy_at_ack = 0; t_rdata = 8'h00;
    while (!done) begin
      @(negedge clk); cyc++;
      cur = {mem_addr, mem_wdata, mem_write, mem_data_sel};
      if (mem_select) begin
        t_sel_hi++;
        if (!seen) begin
          seen = 1; first = cur;
          {t_seen_addr, t_seen_wdata, t_seen_write, t_seen_dsel} = cur;
        end else if (cur !== first) begin
          t_stable = 0;
        end
      end
      if ((port == 0) ? p1_ack : p0_ack) t_other_ack = 1;
      if ((port == 0) ? p0_ack : p1_ack) begin
        t_lat = cyc; t_rdata = (port == 0) ? p0_rdata : p1_rdata;
        t_sel_at_ack = mem_select; t_busy_at_ack = busy; done = 1;
        drive_port(port, addr, wdata, dsel, wr, 1'b0);
      end else if (cyc >= 60) begin
        t_timeout = 1; done = 1;
        drive_port(port, addr, wdata, dsel, wr, 1'b0);
      end
    end
    @(negedge clk);
    t_busy_after = busy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({mem_select, mem_write, mem_data_sel, mem_addr, mem_wdata} !== 19'd0) begin
      n_fail++; $display("FAIL reset_mem_outputs: got %h required 0",
                         {mem_select, mem_write, mem_data_sel, mem_addr, mem_wdata});
    end
    n_checks++;
    if ({p0_ack, p1_ack, p0_rdata, p1_rdata, busy} !== 19'd0) begin
      n_fail++; $display("FAIL reset_port_outputs: got %h required 0",
                         {p0_ack, p1_ack, p0_rdata, p1_rdata, busy});
    end
  endtask

  task automatic test_p1_write();
    logic [7:0] a, d, e;
    a = 8'($urandom); d = 8'($urandom);
    run_txn(1, a, d, 1'b1, 1'b1);
    model_txn(1, a, d, 1'b1, 1'b1, e);
    n_checks++;
    if (t_lat !== 3) begin n_fail++; $display("FAIL p1_write_latency: got %0d required 3", t_lat); end
    n_checks++;
    if (t_rdata !== e) begin n_fail++; $display("FAIL p1_write_rdata_held: got %h required %h", t_rdata, e); end
    n_checks++;
    if (t_other_ack !== 1'b0) begin n_fail++; $display("FAIL p1_write_p0_ack: got 1 required 0"); end
  endtask

  task automatic test_p1_read_code();
    logic [7:0] e;
    run_txn(0, 8'h05, 8'hA7, 1'b0, 1'b1);
    model_txn(0, 8'h05, 8'hA7, 1'b0, 1'b1, e);
    run_txn(1, 8'h05, 8'h00, 1'b0, 1'b0);
    model_txn(1, 8'h05, 8'h00, 1'b0, 1'b0, e);
    n_checks++;
    if (t_lat !== 3) begin n_fail++; $display("FAIL p1_read_latency: got %0d required 3", t_lat); end
    n_checks++;
    if (t_sel_hi !== 2) begin n_fail++; $display("FAIL p1_read_select_cycles: got %0d required 2", t_sel_hi); end
    n_checks++;
    if (t_rdata !== 8'hA7 || e !== 8'hA7) begin
      n_fail++; $display("FAIL p1_read_rdata: got %h required %h", t_rdata, 8'hA7);
    end
    n_checks++;
    if (t_other_ack !== 1'b0) begin n_fail++; $display("FAIL p1_read_p0_ack: got 1 required 0"); end
    n_checks++;
    if ({t_busy_at_ack, t_busy_after} !== 2'b10) begin
      n_fail++; $display("FAIL p1_read_busy: got %b required 10", {t_busy_at_ack, t_busy_after});
    end
  endtask

  task automatic test_write_then_read();
    logic [7:0] e;
    run_txn(0, 8'h02, 8'h3C, 1'b1, 1'b1);
    model_txn(0, 8'h02, 8'h3C, 1'b1, 1'b1, e);
    n_checks++;
    if (t_sel_at_ack !== 1'b0) begin n_fail++; $display("FAIL wr_rd_select_gap: got select=1 required 0"); end
    run_txn(1, 8'h02, 8'h00, 1'b1, 1'b0);
    model_txn(1, 8'h02, 8'h00, 1'b1, 1'b0, e);
    n_checks++;
    if (t_rdata !== e) begin n_fail++; $display("FAIL wr_rd_rdata: got %h required %h", t_rdata, e); end
  endtask

  task automatic test_wait_states();
    logic [7:0] a, d, e;
    mem_wait = 3;
    a = 8'($urandom);
    run_txn(0, a, 8'h00, 1'b0, 1'b0);
    model_txn(0, a, 8'h00, 1'b0, 1'b0, e);
    n_checks++;
    if (t_lat !== 6) begin n_fail++; $display("FAIL wait_read_latency: got %0d required 6", t_lat); end
    n_checks++;
    if (t_sel_hi !== 5) begin n_fail++; $display("FAIL wait_select_cycles: got %0d required 5", t_sel_hi); end
    n_checks++;
    if (t_rdata !== e) begin n_fail++; $display("FAIL wait_read_rdata: got %h required %h", t_rdata, e); end
    a = 8'($urandom); d = 8'($urandom);
    run_txn(1, a, d, 1'b1, 1'b1);
    model_txn(1, a, d, 1'b1, 1'b1, e);
    n_checks++;
    if ({t_stable, t_seen_addr, t_seen_wdata, t_seen_write, t_seen_dsel} !== {1'b1, a, d, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL wait_write_stable: got %h required %h",
        {t_stable, t_seen_addr, t_seen_wdata, t_seen_write, t_seen_dsel}, {1'b1, a, d, 1'b1, 1'b1});
    end
    n_checks++;
    if (t_lat !== 6) begin n_fail++; $display("FAIL wait_write_latency: got %0d required 6", t_lat); end
    mem_wait = 0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a [2];
    logic [7:0] e, got_rd;
    int got, cyc, exp_w;
    bit dual, stray;
    do_reset();
    a[0] = 8'($urandom); a[1] = 8'($urandom);
    @(negedge clk);
    drive_port(0, a[0], 8'h00, 1'b1, 1'b0, 1'b1);
    drive_port(1, a[1], 8'h00, 1'b1, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      got = -1; cyc = 0; dual = 0;
      while (got < 0 && cyc < 40) begin
        @(negedge clk); cyc++;
        if (p0_ack && p1_ack) dual = 1;
        if (p0_ack) got = 0; else if (p1_ack) got = 1;
      end
`ifdef SPELL_ARB_ROUND_ROBIN_EN
      exp_w = m_last ? 0 : 1;
`else
      exp_w = 0;
`endif
      got_rd = (exp_w == 0) ? p0_rdata : p1_rdata;
      model_txn(exp_w, a[exp_w], 8'h00, 1'b1, 1'b0, e);
      n_checks++;
      if (got !== exp_w || dual) begin
        n_fail++; $display("FAIL b2b_winner_round%0d: got %0d (dual=%0d) required %0d", r, got, dual, exp_w);
      end
      n_checks++;
      if (cyc !== 3) begin n_fail++; $display("FAIL b2b_latency_round%0d: got %0d required 3", r, cyc); end
      n_checks++;
      if (got_rd !== e) begin n_fail++; $display("FAIL b2b_rdata_round%0d: got %h required %h", r, got_rd, e); end
      if (got < 0 || r == 2) begin
        p0_req = 1'b0; p1_req = 1'b0;
        if (got < 0) break;
      end else begin
        drive_port(got, a[got], 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        a[got] = 8'($urandom);
        drive_port(got, a[got], 8'h00, 1'b1, 1'b0, 1'b1);
      end
    end
    stray = 0;
    repeat (4) begin @(negedge clk); if (p0_ack || p1_ack || busy) stray = 1; end
    n_checks++;
    if (stray) begin n_fail++; $display("FAIL b2b_idle_after: got activity required none"); end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] a, e;
    bit sel_busy, stray;
    a = 8'($urandom);
    @(negedge clk);
    drive_port(0, a, 8'h00, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    sel_busy = mem_select && busy;
    rst = 1'b1; p0_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!sel_busy || {mem_select, busy, p0_ack, p1_ack} !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_abort: got before=%0d after=%b required 1/0000",
                         sel_busy, {mem_select, busy, p0_ack, p1_ack});
    end
    rst = 1'b0;
    m_last = 1'b1; m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
    stray = 0;
    repeat (3) begin @(negedge clk); if (p0_ack || p1_ack || mem_select) stray = 1; end
    n_checks++;
    if (stray || p0_rdata !== m_rdata[0]) begin
      n_fail++; $display("FAIL midreset_quiet: got stray=%0d rdata=%h required 0/%h", stray, p0_rdata, m_rdata[0]);
    end
    run_txn(0, a, 8'h00, 1'b1, 1'b0);
    model_txn(0, a, 8'h00, 1'b1, 1'b0, e);
    n_checks++;
    if (t_lat !== 3 || t_rdata !== e) begin
      n_fail++; $display("FAIL midreset_reissue: got lat=%0d rdata=%h required 3/%h", t_lat, t_rdata, e);
    end
  endtask

  task automatic test_random();
    int port, w;
    logic [7:0] a, d, e, other;
    logic ds, wr;
    for (int i = 0; i < 12; i++) begin
      port = int'($urandom_range(0, 1)); w = int'($urandom_range(0, 2));
      a = 8'($urandom_range(0, 15)); d = 8'($urandom);
      ds = 1'($urandom); wr = 1'($urandom);
      mem_wait = w;
      run_txn(port, a, d, ds, wr);
      model_txn(port, a, d, ds, wr, e);
      other = (port == 0) ? p1_rdata : p0_rdata;
      n_checks++;
      if (t_lat !== 3 + w || t_other_ack) begin
        n_fail++; $display("FAIL random%0d_latency: got %0d other_ack=%0d required %0d", i, t_lat, t_other_ack, 3 + w);
      end
      n_checks++;
      if (t_rdata !== e || other !== m_rdata[1 - port]) begin
        n_fail++; $display("FAIL random%0d_rdata: got %h/%h required %h/%h", i, t_rdata, other, e, m_rdata[1 - port]);
      end
    end
    mem_wait = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_code[i] = dflt(8'(i), 1'b0);
      ref_data[i] = dflt(8'(i), 1'b1);
    end
    m_last = 1'b1; m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
    test_reset();
    test_p1_write();
    test_p1_read_code();
    test_write_then_read();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
